// File: rtl/ocp_copy_dma_pkg.sv
// Shared constants for ocp_copy_dma: bus widths, OCP command/response codes
// and the copy engine state encoding.
package ocp_copy_dma_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned BEN_WIDTH  = 4;

    typedef enum logic [2:0] {
        OCP_CMD_IDLE  = 3'd0,
        OCP_CMD_WRITE = 3'd1,
        OCP_CMD_READ  = 3'd2
    } ocp_cmd_e;

    typedef enum logic [1:0] {
        OCP_RESP_NULL = 2'd0,
        OCP_RESP_DVA  = 2'd1,
        OCP_RESP_FAIL = 2'd2,
        OCP_RESP_ERR  = 2'd3
    } ocp_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_FINISH  = 3'd4
    } state_e;

endpackage

// File: rtl/ocp_copy_dma_if.sv
// OCP request/response bundle between the copy DMA (master) and the fabric
// targets such as rom_top and RAM (slave).
interface ocp_copy_dma_if;
    import ocp_copy_dma_pkg::*;

    logic [ADDR_WIDTH-1:0] MAddr;
    logic [2:0]            MCmd;
    logic [DATA_WIDTH-1:0] MData;
    logic [BEN_WIDTH-1:0]  MByteEn;
    logic                  SCmdAccept;
    logic [DATA_WIDTH-1:0] SData;
    logic [1:0]            SResp;

    modport master (
        output MAddr, MCmd, MData, MByteEn,
        input  SCmdAccept, SData, SResp
    );

    modport slave (
        input  MAddr, MCmd, MData, MByteEn,
        output SCmdAccept, SData, SResp
    );

endinterface

// File: rtl/ocp_copy_dma.sv
// Single-channel OCP word-copy master: read one word, post its write, advance.
// Optional running checksum output enabled by OCP_COPY_DMA_CSUM_EN.
module ocp_copy_dma
    import ocp_copy_dma_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_src,
    input  logic [ADDR_WIDTH-1:0] i_dst,
    input  logic [CNT_WIDTH-1:0]  i_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
`ifdef OCP_COPY_DMA_CSUM_EN
    output logic [DATA_WIDTH-1:0] o_csum,
`endif
    ocp_copy_dma_if.master        ocp
);

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    state_e                state, state_n;
    logic [ADDR_WIDTH-1:0] src_q, dst_q;
    logic [CNT_WIDTH-1:0]  rem_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;
`ifdef OCP_COPY_DMA_CSUM_EN
    logic [DATA_WIDTH-1:0] csum_q;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= ST_IDLE;
            src_q  <= '0;
            dst_q  <= '0;
            rem_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
`ifdef OCP_COPY_DMA_CSUM_EN
            csum_q <= '0;
`endif
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        src_q  <= i_src & WORD_MASK;
                        dst_q  <= i_dst & WORD_MASK;
                        rem_q  <= i_count;
                        err_q  <= 1'b0;
`ifdef OCP_COPY_DMA_CSUM_EN
                        csum_q <= '0;
`endif
                    end
                end
                ST_RD_WAIT: begin
                    if (ocp.SResp == OCP_RESP_DVA) begin
                        data_q <= ocp.SData;
`ifdef OCP_COPY_DMA_CSUM_EN
                        csum_q <= csum_q + ocp.SData;
`endif
                    end else if (ocp.SResp != OCP_RESP_NULL) begin
                        err_q <= 1'b1;
                    end
                end
                ST_WR_REQ: begin
                    // Addresses wrap modulo 2^ADDR_WIDTH by natural overflow
                    if (ocp.SCmdAccept) begin
                        src_q <= src_q + ADDR_WIDTH'(4);
                        dst_q <= dst_q + ADDR_WIDTH'(4);
                        rem_q <= rem_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n     = state;
        ocp.MCmd    = OCP_CMD_IDLE;
        ocp.MAddr   = '0;
        ocp.MData   = '0;
        ocp.MByteEn = '0;
        case (state)
            ST_IDLE: begin
                if (i_start)
                    state_n = (i_count == '0) ? ST_FINISH : ST_RD_REQ;
            end
            ST_RD_REQ: begin
                ocp.MCmd    = OCP_CMD_READ;
                ocp.MAddr   = src_q;
                ocp.MByteEn = '1;
                if (ocp.SCmdAccept)
                    state_n = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (ocp.SResp == OCP_RESP_DVA)
                    state_n = ST_WR_REQ;
                else if (ocp.SResp != OCP_RESP_NULL)
                    state_n = ST_FINISH;
            end
            ST_WR_REQ: begin
                ocp.MCmd    = OCP_CMD_WRITE;
                ocp.MAddr   = dst_q;
                ocp.MData   = data_q;
                ocp.MByteEn = '1;
                if (ocp.SCmdAccept)
                    state_n = (rem_q == CNT_WIDTH'(1)) ? ST_FINISH : ST_RD_REQ;
            end
            ST_FINISH: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    assign o_busy = (state == ST_RD_REQ) || (state == ST_RD_WAIT) || (state == ST_WR_REQ);
    assign o_done = (state == ST_FINISH);
    assign o_err  = err_q;
`ifdef OCP_COPY_DMA_CSUM_EN
    assign o_csum = csum_q;
`endif

endmodule

// File: tb/tb_ocp_copy_dma.sv
// Directed bench for ocp_copy_dma: behavioural ROM/RAM slave with programmable
// accept delays and error injection; read word at address A is {16'hB007, A[15:0]}.
module tb_ocp_copy_dma;
    import ocp_copy_dma_pkg::*;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_src = '0;
    logic [31:0] i_dst = '0;
    logic [15:0] i_count = '0;
    logic        o_busy, o_done, o_err;
`ifdef OCP_COPY_DMA_CSUM_EN
    logic [31:0] o_csum;
`endif

    ocp_copy_dma_if bus ();

    ocp_copy_dma #(.CNT_WIDTH(16)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .i_start (i_start),
        .i_src   (i_src),
        .i_dst   (i_dst),
        .i_count (i_count),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_err   (o_err),
`ifdef OCP_COPY_DMA_CSUM_EN
        .o_csum  (o_csum),
`endif
        .ocp     (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // slave model state
    int          rd_delay = 0, wr_delay = 0, err_idx = 0;
    int          rd_cnt = 0, wr_cnt = 0, viol = 0, stall_max = 0, be_bad = 0, done_cnt = 0;
    int          wcnt = 0, d = 0;
    logic        pend = 1'b0;
    logic [1:0]  pend_resp = '0;
    logic [31:0] pend_data = '0;
    logic [70:0] snap = '0;
    logic [31:0] rlog [0:15];
    logic [31:0] wlog_addr [0:15];
    logic [31:0] wlog_data [0:15];

    initial begin
        bus.SCmdAccept = 1'b0;
        bus.SData      = '0;
        bus.SResp      = '0;
    end

    always @(negedge clk) begin
        bus.SResp      = OCP_RESP_NULL;
        bus.SData      = '0;
        bus.SCmdAccept = 1'b0;
        if (o_done) done_cnt++;
        if (!nrst) begin
            pend = 1'b0;
            wcnt = 0;
        end else begin
            if (pend) begin
                bus.SResp = pend_resp;
                bus.SData = pend_data;
                pend      = 1'b0;
            end
            if (bus.MCmd != OCP_CMD_IDLE) begin
                if (wcnt == 0)
                    snap = {bus.MAddr, bus.MData, bus.MCmd, bus.MByteEn};
                else if (snap !== {bus.MAddr, bus.MData, bus.MCmd, bus.MByteEn})
                    viol++;
                d = (bus.MCmd == OCP_CMD_READ) ? rd_delay : wr_delay;
                if (wcnt >= d) begin
                    bus.SCmdAccept = 1'b1;
                    wcnt = 0;
                    if (bus.MByteEn !== 4'hf) be_bad++;
                    if (bus.MCmd == OCP_CMD_READ) begin
                        if (rd_cnt < 16) rlog[rd_cnt] = bus.MAddr;
                        rd_cnt++;
                        pend      = 1'b1;
                        pend_resp = (rd_cnt == err_idx) ? OCP_RESP_ERR : OCP_RESP_DVA;
                        pend_data = {16'hB007, bus.MAddr[15:0]};
                    end else begin
                        if (wr_cnt < 16) begin
                            wlog_addr[wr_cnt] = bus.MAddr;
                            wlog_data[wr_cnt] = bus.MData;
                        end
                        wr_cnt++;
                    end
                end else begin
                    wcnt++;
                    if (wcnt > stall_max) stall_max = wcnt;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        rd_cnt = 0; wr_cnt = 0; viol = 0; stall_max = 0; done_cnt = 0; err_idx = 0;
        for (int i = 0; i < 16; i++) begin
            rlog[i] = '0; wlog_addr[i] = '0; wlog_data[i] = '0;
        end
    endtask

    task automatic start(input logic [31:0] s, input logic [31:0] dd, input logic [15:0] c);
        step();
        i_src = s; i_dst = dd; i_count = c; i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (o_done) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #2;
        check("rst_mcmd", {29'd0, bus.MCmd}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_err", {31'd0, o_err}, 32'd0);
        check("rst_maddr", bus.MAddr, 32'd0);
        step();
        nrst = 1'b1;
        step();

        // T1 basic copy with accept delays
        clr(); rd_delay = 1; wr_delay = 2;
        start(32'h0, 32'h1000, 16'd4);
        check("t1_busy", {31'd0, o_busy}, 32'd1);
        wait_done("t1_done_seen");
        step();
        check("t1_done_once", done_cnt, 32'd1);
        check("t1_reads", rd_cnt, 32'd4);
        check("t1_writes", wr_cnt, 32'd4);
        check("t1_err", {31'd0, o_err}, 32'd0);
        check("t1_busy_idle", {31'd0, o_busy}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("t1_waddr", wlog_addr[i], 32'h1000 + 32'(4 * i));
            check("t1_wdata", wlog_data[i], 32'hB007_0000 + 32'(4 * i));
        end

        // T2 zero count; start during FINISH is ignored
        clr();
        start(32'h0, 32'h1000, 16'd0);
        check("t2_done_next", {31'd0, o_done}, 32'd1);
        check("t2_busy", {31'd0, o_busy}, 32'd0);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check("t2_fin_start_ign", {31'd0, o_done}, 32'd0);
        step();
        check("t2_still_idle", {31'd0, o_done | o_busy}, 32'd0);
        check("t2_done_cnt", done_cnt, 32'd1);
        check("t2_no_traffic", rd_cnt + wr_cnt, 32'd0);

        // T3 error response on the 2nd read
        clr(); rd_delay = 0; wr_delay = 0; err_idx = 2;
        start(32'h4, 32'h1000, 16'd3);
        wait_done("t3_done_seen");
        check("t3_err", {31'd0, o_err}, 32'd1);
        for (int i = 0; i < 5; i++) step();
        check("t3_reads", rd_cnt, 32'd2);
        check("t3_rd2_addr", rlog[1], 32'h8);
        check("t3_writes", wr_cnt, 32'd1);
        check("t3_waddr", wlog_addr[0], 32'h1000);
        check("t3_wdata", wlog_data[0], 32'hB007_0004);
        check("t3_done_cnt", done_cnt, 32'd1);
        check("t3_err_sticky", {31'd0, o_err}, 32'd1);

        // T4 write backpressure, low address bits ignored
        clr(); rd_delay = 0; wr_delay = 5;
        start(32'h13, 32'h1002, 16'd2);
        check("t4_err_cleared", {31'd0, o_err}, 32'd0);
        wait_done("t4_done_seen");
        check("t4_stall", stall_max, 32'd5);
        check("t4_stable", viol, 32'd0);
        check("t4_rd0_addr", rlog[0], 32'h10);
        check("t4_waddr0", wlog_addr[0], 32'h1000);
        check("t4_wdata0", wlog_data[0], 32'hB007_0010);
        check("t4_waddr1", wlog_addr[1], 32'h1004);
        check("t4_wdata1", wlog_data[1], 32'hB007_0014);

        // T5 reset during RD_WAIT of word 2
        clr(); rd_delay = 0; wr_delay = 0;
        start(32'h0, 32'h1000, 16'd4);
        for (int i = 0; i < 50 && rd_cnt < 2; i++) step();
        step();
        check("t5_busy_pre", {31'd0, o_busy}, 32'd1);
        nrst = 1'b0;
        #1;
        check("t5_busy_rst", {31'd0, o_busy}, 32'd0);
        check("t5_mcmd_rst", {29'd0, bus.MCmd}, 32'd0);
        step();
        step();
        nrst = 1'b1;
        check("t5_no_done", done_cnt, 32'd0);
        check("t5_writes", wr_cnt, 32'd1);
        clr();
        start(32'h8, 32'h1000, 16'd2);
        wait_done("t5_done_seen");
        check("t5_wdata0", wlog_data[0], 32'hB007_0008);
        check("t5_wdata1", wlog_data[1], 32'hB007_000C);
        check("t5_writes2", wr_cnt, 32'd2);

        // T7 address wrap-around
        clr();
        start(32'hFFFF_FFFC, 32'hFFFF_FFFC, 16'd2);
        wait_done("t7_done_seen");
        check("t7_rd1_addr", rlog[1], 32'h0);
        check("t7_waddr1", wlog_addr[1], 32'h0);
        check("t7_wdata0", wlog_data[0], 32'hB007_FFFC);
        check("t7_wdata1", wlog_data[1], 32'hB007_0000);

`ifdef OCP_COPY_DMA_CSUM_EN
        // T6 checksum; start mid-copy ignored
        clr(); rd_delay = 1; wr_delay = 1;
        start(32'h0, 32'h1000, 16'd4);
        step(); step(); step();
        i_src = 32'h100; i_count = 16'd1; i_start = 1'b1;
        step();
        i_start = 1'b0;
        wait_done("t6_done_seen");
        check("t6_csum", o_csum, 32'hC01C_0018);
        step();
        check("t6_writes", wr_cnt, 32'd4);
        check("t6_done_cnt", done_cnt, 32'd1);
        check("t6_rd3_addr", rlog[3], 32'hC);
`endif

        check("byteen_all", be_bad, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
